// File: rtl/alu_pkg.sv
// Shared definitions for the lab MIPS ALU blocks.
//   state_t    : control state encoding of the bit-serial add/sub unit
//   OP_ADD/SUB : operation select encoding
//   DEF_WIDTH  : default datapath width
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/single_bit.sv
// One-bit add/subtract cell (purely combinational).
//   a, b : operand bits
//   cin  : carry in
//   op   : 0 = add, 1 = subtract (b is inverted; the +1 enters through cin)
//   sum  : sum bit
//   cout : carry out
module single_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic sum,
  output logic cout
);

  logic b_eff;

  assign b_eff = b ^ op;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor. One single_bit cell is
// reused for WIDTH cycles, LSB first, with a carry flop between bits.
//   clk, rstn : clock, asynchronous active-low reset
//   start     : request, sampled only while idle
//   a, b, op  : operands and operation (0 add, 1 subtract), latched on start
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   result    : sum/difference, held until the next completion
//   cout      : carry out of the MSB (subtract: 1 = no borrow)
//   overflow  : signed overflow
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             op_r;
  logic             carry;
  logic             msb_cin;
  logic [CNT_W-1:0] cnt;
  // Holds the WIDTH-1 sum bits produced so far; the last bit is appended
  // directly when the result is captured.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_ext;
  logic             cell_sum;
  logic             cell_cout;

  single_bit u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .op   (op_r),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // New sum bit enters at the top; after the final bit this is the full result.
  assign acc_ext = {cell_sum, acc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      op_r     <= 1'b0;
      carry    <= 1'b0;
      msb_cin  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Accept: latch operands; subtract seeds the carry with the +1.
        S_IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            op_r  <= op;
            carry <= (op == OP_SUB);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        // One bit per cycle, LSB first.
        S_RUN: begin
          acc   <= acc_ext[WIDTH-1:1];
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= cell_cout;
          cnt   <= cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt == CNT_PENULT) begin
            msb_cin <= cell_cout;
          end
          if (cnt == CNT_LAST) begin
            result   <= acc_ext;
            cout     <= cell_cout;
            overflow <= msb_cin ^ cell_cout;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_FIN;
          end
        end
        // Completion cycle; start is ignored here.
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
